fact_perm_unit: RTL and testbench

Parametrised successor to the calculator's factorial down-counter. It owns both the down-counting operand sequence and the accumulating multiply, and computes n! (factorial mode) or P(n,k) = n·(n-1)·…·(n-k+1) (permutation mode). It sits between the calculator's operation decoder and the result/display path, uses a START/BUSY/DONE handshake, and performs one multiply per clock with sticky overflow detection.

---
 rtl/fact_pkg.sv | 18 +
 rtl/fact_perm_unit_if.sv | 31 +++
 rtl/fact_down_cnt.sv | 37 +++
 rtl/fact_perm_unit.sv | 112 +++++++++++
 tb/tb_fact_perm_unit.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/fact_pkg.sv
// Shared types and defaults for the factorial / permutation unit.
package fact_pkg;

  localparam int unsigned W_DEF  = 9;
  localparam int unsigned RW_DEF = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  typedef enum logic {
    MODE_FACT = 1'b0,
    MODE_PERM = 1'b1
  } mode_t;

endpackage

// File: rtl/fact_perm_unit_if.sv
// START/BUSY/DONE handshake and operand/result bus of fact_perm_unit.
interface fact_perm_unit_if
  import fact_pkg::*;
#(
  parameter int unsigned W  = W_DEF,
  parameter int unsigned RW = RW_DEF
) ();

  logic          START;
  logic          MODE;
  logic [W-1:0]  N;
  logic [W-1:0]  K;
  logic          ABORT;
  logic          BUSY;
  logic          DONE;
  logic [RW-1:0] RESULT;
  logic          OVF;
  logic [W-1:0]  CNT_OUT;
  logic          FACT_END;

  modport master (
    output START, MODE, N, K, ABORT,
    input  BUSY, DONE, RESULT, OVF, CNT_OUT, FACT_END
  );

  modport slave (
    input  START, MODE, N, K, ABORT,
    output BUSY, DONE, RESULT, OVF, CNT_OUT, FACT_END
  );

endinterface

// File: rtl/fact_down_cnt.sv
// Loadable down-counter pair: multiplier operand (cnt) and remaining steps.
module fact_down_cnt #(
  parameter int unsigned W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         dec,
  input  logic         clr,
  input  logic [W-1:0] cnt_init,
  input  logic [W-1:0] steps_init,
  output logic [W-1:0] cnt,
  output logic [W-1:0] steps,
  output logic         terminal,
  output logic         zero
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      steps <= '0;
    end else if (clr) begin
      cnt   <= '0;
      steps <= '0;
    end else if (load) begin
      cnt   <= cnt_init;
      steps <= steps_init;
    end else if (dec) begin
      cnt   <= cnt - W'(1);
      steps <= steps - W'(1);
    end
  end

  assign terminal = (steps == W'(1));
  assign zero     = (steps == '0);

endmodule

// File: rtl/fact_perm_unit.sv
// Computes N! or P(N,K) with one multiply per clock and sticky overflow.
module fact_perm_unit
  import fact_pkg::*;
#(
  parameter int unsigned W  = W_DEF,
  parameter int unsigned RW = RW_DEF
) (
  input  logic           CLK,
  input  logic           RST,
  fact_perm_unit_if.slave bus
);

  state_t          state;
  logic [RW-1:0]   acc;
  logic            ovf;
  logic            busy;
  logic            done;

  logic [W-1:0]    cnt;
  logic [W-1:0]    steps;
  logic            terminal;
  logic            zero;

  logic            start_ok;
  logic            dec;
  logic            clr;
  logic            perm_empty;
  logic [W-1:0]    steps_init;
  logic [W+RW-1:0] prod;

  always_comb begin
    start_ok   = (state == S_IDLE) && bus.START && !bus.ABORT;
    dec        = (state == S_MUL) && !bus.ABORT;
    clr        = (state == S_MUL) && bus.ABORT;
    steps_init = (bus.MODE == MODE_PERM) ? bus.K : bus.N;
    perm_empty = (bus.MODE == MODE_PERM) && (bus.K > bus.N);
    prod       = (W+RW)'(acc) * (W+RW)'(cnt);
  end

  fact_down_cnt #(.W(W)) u_cnt (
    .clk        (CLK),
    .rst_n      (RST),
    .load       (start_ok),
    .dec        (dec),
    .clr        (clr),
    .cnt_init   (bus.N),
    .steps_init (steps_init),
    .cnt        (cnt),
    .steps      (steps),
    .terminal   (terminal),
    .zero       (zero)
  );

  // DONE is registered out of FIN, so it is seen the cycle after FIN.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= S_IDLE;
      acc   <= '0;
      ovf   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start_ok) begin
            ovf <= 1'b0;
            if (perm_empty) begin
              acc   <= '0;
              state <= S_FIN;
            end else if (steps_init == '0) begin
              acc   <= RW'(1);
              state <= S_FIN;
            end else begin
              acc   <= RW'(1);
              busy  <= 1'b1;
              state <= S_MUL;
            end
          end
        end
        S_MUL: begin
          if (bus.ABORT) begin
            acc   <= '0;
            ovf   <= 1'b0;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            acc <= prod[RW-1:0];
            ovf <= ovf | (|prod[W+RW-1:RW]);
            if (terminal || zero) begin
              busy  <= 1'b0;
              state <= S_FIN;
            end
          end
        end
        S_FIN: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.BUSY     = busy;
  assign bus.DONE     = done;
  assign bus.RESULT   = acc;
  assign bus.OVF      = ovf;
  assign bus.CNT_OUT  = cnt;
  assign bus.FACT_END = (state == S_MUL) && terminal;

endmodule

// File: tb/tb_fact_perm_unit.sv
// Directed and randomized checks of fact_perm_unit against an arithmetic reference.
module tb_fact_perm_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fact_perm_unit_if #(.W(9), .RW(32)) bus ();

  fact_perm_unit #(.W(9), .RW(32)) dut (
    .CLK (clk),
    .RST (rst_n),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: product of the descending factors n, n-1, ... taken `steps` times,
  // truncated to 32 bits after each multiply, overflow if any product exceeds 32 bits.
  function automatic void ref_model(input bit mode, input int n, input int k,
                                    output int steps, output longint res, output bit ovf);
    longint unsigned a;
    longint unsigned p;
    ovf = 1'b0;
    if (mode && k > n) begin
      steps = 0;
      res   = 0;
      return;
    end
    steps = mode ? k : n;
    a = 1;
    for (int i = 0; i < steps; i++) begin
      p = a * longint'(n - i);
      if ((p >> 32) != 0) ovf = 1'b1;
      a = p & 64'hFFFF_FFFF;
    end
    res = longint'(a);
  endfunction

  task automatic run_op(input bit mode, input int n, input int k,
                        input int abort_at, input int restart_at, input string tag);
    int steps;
    longint er;
    bit eo;
    int busy_n = 0;
    int fe_n = 0;
    int done_n = 0;
    int fe_cyc = -1;
    int done_cyc = -1;
    ref_model(mode, n, k, steps, er, eo);
    @(negedge clk);
    bus.START = 1'b1;
    bus.MODE  = mode;
    bus.N     = n[8:0];
    bus.K     = k[8:0];
    bus.ABORT = 1'b0;
    @(posedge clk);
    #1;
    bus.START = 1'b0;
    for (int cyc = 0; cyc <= steps + 4; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk);
        #1;
      end
      if (bus.BUSY) busy_n++;
      if (bus.FACT_END) begin
        fe_n++;
        fe_cyc = cyc;
      end
      if (bus.DONE) begin
        done_n++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      bus.ABORT = (abort_at > 0) && (cyc == abort_at - 1);
      bus.START = (restart_at > 0) && (cyc == restart_at - 1);
    end
    bus.ABORT = 1'b0;
    bus.START = 1'b0;
    if (abort_at > 0) begin
      check({tag, " abort_done"}, done_n, 0);
      check({tag, " abort_busy"}, busy_n, abort_at);
      check({tag, " abort_result"}, bus.RESULT, 0);
      check({tag, " abort_ovf"}, bus.OVF, 0);
      check({tag, " abort_cnt"}, bus.CNT_OUT, 0);
    end else begin
      check({tag, " latency"}, done_cyc, steps + 1);
      check({tag, " done_pulses"}, done_n, 1);
      check({tag, " busy_cycles"}, busy_n, steps);
      check({tag, " fact_end_n"}, fe_n, (steps > 0) ? 1 : 0);
      if (steps > 0) check({tag, " fact_end_cyc"}, fe_cyc, steps - 1);
      check({tag, " result"}, bus.RESULT, er);
      check({tag, " ovf"}, bus.OVF, eo);
      check({tag, " cnt_out"}, bus.CNT_OUT, n - steps);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy"}, bus.BUSY, 0);
    check({tag, " done"}, bus.DONE, 0);
    check({tag, " result"}, bus.RESULT, 0);
    check({tag, " ovf"}, bus.OVF, 0);
    check({tag, " cnt"}, bus.CNT_OUT, 0);
    check({tag, " fact_end"}, bus.FACT_END, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_n;
    int done_n;
    int steps;
    longint er;
    bit eo;
    bit m;
    int n;
    int k;
    int ab;

    bus.START = 1'b0;
    bus.MODE  = 1'b0;
    bus.N     = '0;
    bus.K     = '0;
    bus.ABORT = 1'b0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_op(1'b0, 5, 0, 0, 0, "fact5");
    run_op(1'b0, 0, 0, 0, 0, "fact0");
    run_op(1'b1, 9, 0, 0, 0, "perm9_0");
    run_op(1'b1, 7, 3, 0, 0, "perm7_3");
    run_op(1'b1, 7, 8, 0, 0, "perm7_8");
    run_op(1'b0, 12, 0, 0, 0, "fact12");
    run_op(1'b0, 13, 0, 0, 0, "fact13");
    run_op(1'b0, 6, 0, 0, 2, "fact6_restart");

    // START together with ABORT in IDLE must not start anything.
    @(negedge clk);
    bus.START = 1'b1;
    bus.ABORT = 1'b1;
    bus.MODE  = 1'b0;
    bus.N     = 9'd3;
    @(posedge clk);
    #1;
    bus.START = 1'b0;
    bus.ABORT = 1'b0;
    busy_n = 0;
    done_n = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus.BUSY) busy_n++;
      if (bus.DONE) done_n++;
      @(posedge clk);
      #1;
    end
    check("start_abort busy", busy_n, 0);
    check("start_abort done", done_n, 0);
    check("start_abort result_held", bus.RESULT, 720);

    run_op(1'b0, 6, 0, 3, 0, "fact6_abort");

    // Asynchronous reset between clock edges in the middle of a multiply run.
    @(negedge clk);
    bus.START = 1'b1;
    bus.MODE  = 1'b0;
    bus.N     = 9'd10;
    @(posedge clk);
    #1;
    bus.START = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check("pre_reset busy", bus.BUSY, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1'b0, 4, 0, 0, 0, "fact4_after_reset");

    for (int it = 0; it < 25; it++) begin
      m = 1'($urandom % 2);
      n = ($urandom % 8 == 0) ? int'($urandom_range(100, 511)) : int'($urandom_range(0, 16));
      k = int'($urandom_range(0, n + 3));
      if (k > 511) k = 511;
      ref_model(m, n, k, steps, er, eo);
      ab = (steps > 0 && ($urandom % 5 == 0)) ? int'($urandom_range(1, steps)) : 0;
      run_op(m, n, k, ab, 0, $sformatf("rnd%0d", it));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
